// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
//
// Accepts a message as a stream of byte beats and emits the SHA-256 padded
// message as a sequence of 512-bit blocks for a compression core. Padding
// appends 0x80, zero fill, and the 64-bit big-endian message bit length.
//
// Ports
//   clk        : single clock, all logic on its rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : input byte beat present
//   in_data    : message byte
//   in_last    : beat is the final beat of the message
//   in_empty   : with in_last, the beat carries no byte
//   in_ready   : padder accepts a beat this cycle
//   blk_valid  : 512-bit block presented to the core
//   blk_ready  : core accepts the block
//   blk_data   : block, byte 0 at [511:504], byte 63 at [7:0]
//   blk_first  : block is the first block of its message
//   blk_last   : block is the final (length-bearing) block of its message
// -----------------------------------------------------------------------------
module sha256_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    PAD80 = 3'd1,
    ZERO  = 3'd2,
    LEN   = 3'd3,
    EMIT  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [5:0]     idx_r;
  logic [5:0]     idx_nxt_s;
  logic [63:0]    len_r;
  logic [63:0]    len_nxt_s;
  logic           first_pend_r;
  logic           first_pend_nxt_s;
  logic           pad_pend_r;
  logic           pad_pend_nxt_s;
  // Set when the block being emitted is a padding-overflow block, so the
  // next block must continue with zero fill before the length.
  logic           ovf_r;
  logic           ovf_nxt_s;
  logic           blk_first_r;
  logic           blk_first_nxt_s;
  logic           blk_last_r;
  logic           blk_last_nxt_s;
  logic           in_ready_r;
  logic           blk_valid_r;
  logic [511:0]   buf_r;

  logic           accept_s;
  logic           has_byte_s;
  logic           wr_en_s;
  logic [7:0]     wr_byte_s;
  logic           len_wr_s;
  logic           buf_clr_s;

  // in_ready is forced low while reset is asserted so no beat can be taken
  // in the reset cycle itself.
  assign in_ready   = in_ready_r & ~reset;
  assign blk_valid  = blk_valid_r;
  assign blk_data   = buf_r;
  assign blk_first  = blk_first_r;
  assign blk_last   = blk_last_r;

  assign accept_s   = in_valid & in_ready;
  assign has_byte_s = ~(in_last & in_empty);

  // Next-state, counter, flag and buffer-write decode.
  always_comb begin
    state_nxt_s      = state_r;
    idx_nxt_s        = idx_r;
    len_nxt_s        = len_r;
    first_pend_nxt_s = first_pend_r;
    pad_pend_nxt_s   = pad_pend_r;
    ovf_nxt_s        = ovf_r;
    blk_first_nxt_s  = blk_first_r;
    blk_last_nxt_s   = blk_last_r;
    wr_en_s          = 1'b0;
    wr_byte_s        = 8'h00;
    len_wr_s         = 1'b0;
    buf_clr_s        = 1'b0;

    case (state_r)
      LOAD: begin
        if (accept_s) begin
          if (has_byte_s) begin
            wr_en_s   = 1'b1;
            wr_byte_s = in_data;
            idx_nxt_s = idx_r + 6'd1;
            len_nxt_s = len_r + 64'd8;
            if (idx_r == 6'd63) begin
              // Data filled the block; padding (if any) starts in the next one.
              state_nxt_s     = EMIT;
              pad_pend_nxt_s  = in_last;
              ovf_nxt_s       = 1'b0;
              blk_first_nxt_s = first_pend_r;
              blk_last_nxt_s  = 1'b0;
            end else if (in_last) begin
              state_nxt_s = PAD80;
            end else begin
              state_nxt_s = LOAD;
            end
          end else begin
            // Empty terminating beat: nothing written, go straight to padding.
            state_nxt_s = PAD80;
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end

      PAD80: begin
        wr_en_s   = 1'b1;
        wr_byte_s = 8'h80;
        idx_nxt_s = idx_r + 6'd1;
        if (idx_r == 6'd63) begin
          state_nxt_s     = EMIT;
          ovf_nxt_s       = 1'b1;
          blk_first_nxt_s = first_pend_r;
          blk_last_nxt_s  = 1'b0;
        end else if (idx_r == 6'd55) begin
          state_nxt_s = LEN;
        end else begin
          state_nxt_s = ZERO;
        end
      end

      ZERO: begin
        wr_en_s   = 1'b1;
        wr_byte_s = 8'h00;
        idx_nxt_s = idx_r + 6'd1;
        if (idx_r == 6'd55) begin
          state_nxt_s = LEN;
        end else if (idx_r == 6'd63) begin
          state_nxt_s     = EMIT;
          ovf_nxt_s       = 1'b1;
          blk_first_nxt_s = first_pend_r;
          blk_last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ZERO;
        end
      end

      LEN: begin
        len_wr_s        = 1'b1;
        state_nxt_s     = EMIT;
        ovf_nxt_s       = 1'b0;
        blk_first_nxt_s = first_pend_r;
        blk_last_nxt_s  = 1'b1;
      end

      EMIT: begin
        if (blk_ready) begin
          buf_clr_s        = 1'b1;
          idx_nxt_s        = 6'd0;
          first_pend_nxt_s = blk_last_r;
          blk_first_nxt_s  = 1'b0;
          blk_last_nxt_s   = 1'b0;
          if (blk_last_r) begin
            state_nxt_s = LOAD;
            len_nxt_s   = 64'd0;
          end else if (pad_pend_r) begin
            state_nxt_s    = PAD80;
            pad_pend_nxt_s = 1'b0;
          end else if (ovf_r) begin
            state_nxt_s = ZERO;
            ovf_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = EMIT;
        end
      end

      default: begin
        state_nxt_s = LOAD;
        idx_nxt_s   = 6'd0;
      end
    endcase
  end

  // State, counters, flags and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= LOAD;
      idx_r        <= 6'd0;
      len_r        <= 64'd0;
      first_pend_r <= 1'b1;
      pad_pend_r   <= 1'b0;
      ovf_r        <= 1'b0;
      blk_first_r  <= 1'b0;
      blk_last_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      blk_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      len_r        <= len_nxt_s;
      first_pend_r <= first_pend_nxt_s;
      pad_pend_r   <= pad_pend_nxt_s;
      ovf_r        <= ovf_nxt_s;
      blk_first_r  <= blk_first_nxt_s;
      blk_last_r   <= blk_last_nxt_s;
      in_ready_r   <= (state_nxt_s == LOAD);
      blk_valid_r  <= (state_nxt_s == EMIT);
    end
  end

  // Block buffer: cleared after each emitted block so unwritten bytes are zero.
  // Byte i lives at bits [(63-i)*8 +: 8]; 63-i equals ~i for a 6-bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_r <= 512'd0;
    end else if (buf_clr_s) begin
      buf_r <= 512'd0;
    end else if (len_wr_s) begin
      buf_r[63:0] <= len_r;
    end else if (wr_en_s) begin
      buf_r[{~idx_r, 3'b000} +: 8] <= wr_byte_s;
    end else begin
      buf_r <= buf_r;
    end
  end

endmodule
